uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_rx_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Kept separate from the TX package so the state enum names cannot collide.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  localparam int unsigned PrescaleX8  = 8;
  localparam int unsigned PrescaleX16 = 16;
  localparam int unsigned PrescaleX32 = 32;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic prescale_is_legal(input int unsigned p);
    return (p == PrescaleX8) || (p == PrescaleX16) || (p == PrescaleX32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three mid-bit samples and a 2-of-3 vote.
// bit_end marks the last oversample cycle of each bit period.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx,
  output logic                  bit_end,
  output logic                  bit_val
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] half, last;
  logic [2:0]            samp_q, samp_d;
  logic                  wrap;

  assign half = prescale >> 1;
  assign last = prescale - PRESCALE_W'(1);
  // A zero prescale wraps every cycle so the FSM can never stall.
  assign wrap = (edge_cnt_q == last) || (prescale == '0);

  assign bit_end = !clear && wrap;
  assign bit_val = maj3(samp_q);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    samp_d     = samp_q;
    if (clear || wrap) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
    if (edge_cnt_q == half - PRESCALE_W'(1)) samp_d[0] = rx;
    if (edge_cnt_q == half)                  samp_d[1] = rx;
    if (edge_cnt_q == half + PRESCALE_W'(1)) samp_d[2] = rx;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      samp_q     <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: start/data/parity/stop framing with parity and stop checks.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on RX_IN (+2 cycles latency).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_fail_q, par_fail_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  rx_s, bit_end, bit_val, par_exp;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLK) begin
    if (!RST) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], RX_IN};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (state_q == RxIdle),
    .prescale(prescale_q),
    .rx      (rx_s),
    .bit_end (bit_end),
    .bit_val (bit_val)
  );

  assign par_exp = (^shift_q) ^ (par_type_q == ParityOdd);

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    prescale_d     = prescale_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    par_fail_d     = par_fail_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    unique case (state_q)
      RxIdle: begin
        // Track config while idle so the value on the leaving edge is what sticks.
        prescale_d = prescale;
        par_en_d   = parity_enable;
        par_type_d = parity_type;
        par_fail_d = 1'b0;
        bit_cnt_d  = '0;
        if (!rx_s) state_d = RxStart;
      end
      RxStart: begin
        if (bit_end) state_d = bit_val ? RxIdle : RxData;
      end
      RxData: begin
        if (bit_end) begin
          shift_d = (shift_q >> 1) | (DATA_WIDTH'(bit_val) << (DATA_WIDTH - 1));
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? RxParity : RxStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      RxParity: begin
        if (bit_end) begin
          if (bit_val != par_exp) begin
            parity_error_d = 1'b1;
            par_fail_d     = 1'b1;
          end
          state_d = RxStop;
        end
      end
      RxStop: begin
        if (bit_end) begin
          state_d = RxIdle;
          if (!bit_val) begin
            stop_error_d = 1'b1;
          end else if (!par_fail_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= RxIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      prescale_q     <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_fail_q     <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      prescale_q     <= prescale_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      par_fail_q     <= par_fail_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: framing, parity/stop errors, glitch and spike rejection,
// back-to-back frames and mid-frame reset.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] prescale = 6'd8;
  logic          parity_enable = 1'b0;
  logic          parity_type = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid, parity_error, stop_error;

  uart_rx_ctrl #(
    .DATA_WIDTH(DW),
    .PRESCALE_W(PW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .prescale     (prescale),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, dv_cyc = 0;
  int s_dv = 0, s_pe = 0, s_se = 0;
  logic [DW-1:0] dv_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Outputs are observed mid-cycle; each high sample is one cycle of pulse.
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cnt <= dv_cnt + 1;
      dv_cyc <= cyc;
      dv_q.push_back(P_DATA);
    end
    if (parity_error) pe_cnt <= pe_cnt + 1;
    if (stop_error)   se_cnt <= se_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input int edv, input int epe, input int ese);
    check({tag, "_dv"}, 32'(dv_cnt - s_dv), 32'(edv));
    check({tag, "_pe"}, 32'(pe_cnt - s_pe), 32'(epe));
    check({tag, "_se"}, 32'(se_cnt - s_se), 32'(ese));
    s_dv = dv_cnt;
    s_pe = pe_cnt;
    s_se = se_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drives one frame P cycles per bit; spike_bit inverts one cycle at the edge_cnt = P/2 sample,
  // rst_bit asserts reset at the start of that frame bit and returns early.
  task automatic send_frame(input logic [7:0] data, input int p, input bit pen, input bit ptype,
                            input bit pflip, input bit stop_val, input int spike_bit,
                            input int rst_bit, output int t0);
    logic [10:0] fr;
    int          nb;
    fr      = '0;
    fr[8:1] = data;
    if (pen) begin
      fr[9]  = (^data) ^ ptype ^ pflip;
      fr[10] = stop_val;
      nb     = 11;
    end else begin
      fr[9] = stop_val;
      nb    = 10;
    end
    t0 = 0;
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge CLK);
        if (j == 0 && c == 0) begin
          t0            = cyc;
          prescale      = PW'(p);
          parity_enable = pen;
          parity_type   = ptype;
        end
        if (j == rst_bit && c == 0) begin
          RST   = 1'b0;
          RX_IN = 1'b1;
          return;
        end
        RX_IN = fr[j] ^ ((j == spike_bit && c == p / 2 + 1) ? 1'b1 : 1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;

    repeat (3) @(negedge CLK);
    check("rst_pdata", 32'(P_DATA), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_pe", 32'(parity_error), 32'h0);
    check("rst_se", 32'(stop_error), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(RxIdle));
    RST = 1'b1;
    idle(3);

    // P=8, no parity, 0xA5: latency 10*P+1
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    idle(4);
    chk_pulses("a5", 1, 0, 0);
    check("a5_lat", 32'(dv_cyc - t0), 32'(81 + SyncLat));
    check("a5_pdata", 32'(P_DATA), 32'hA5);

    // P=16 even parity, good then bad parity bit
    send_frame(8'h3C, 16, 1'b1, ParityEven, 1'b0, 1'b1, -1, -1, t0);
    idle(4);
    chk_pulses("3c_ok", 1, 0, 0);
    check("3c_pdata", 32'(P_DATA), 32'h3C);
    check("3c_lat", 32'(dv_cyc - t0), 32'(11 * 16 + 1 + SyncLat));
    send_frame(8'h3C, 16, 1'b1, ParityEven, 1'b1, 1'b1, -1, -1, t0);
    idle(4);
    chk_pulses("3c_bad", 0, 1, 0);
    check("3c_keep", 32'(P_DATA), 32'h3C);

    // P=32 odd parity, stop forced 0, then a clean 0xFF
    send_frame(8'h00, 32, 1'b1, ParityOdd, 1'b0, 1'b0, -1, -1, t0);
    idle(4);
    chk_pulses("stop0", 0, 0, 1);
    check("stop0_keep", 32'(P_DATA), 32'h3C);
    send_frame(8'hFF, 32, 1'b1, ParityOdd, 1'b0, 1'b1, -1, -1, t0);
    idle(4);
    chk_pulses("ff", 1, 0, 0);
    check("ff_pdata", 32'(P_DATA), 32'hFF);

    // 3-cycle low glitch at P=16
    prescale      = 6'd16;
    parity_enable = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      RX_IN = 1'b0;
    end
    idle(40);
    check("glitch_state", 32'(dut.state_q), 32'(RxIdle));
    chk_pulses("glitch", 0, 0, 0);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    idle(4);
    chk_pulses("81", 1, 0, 0);
    check("81_pdata", 32'(P_DATA), 32'h81);

    // Inverted single-cycle spike in data bit 2 (frame bit 3)
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1, t0);
    idle(4);
    chk_pulses("spike", 1, 0, 0);
    check("spike_pdata", 32'(P_DATA), 32'h55);

    // Back-to-back 0x12, 0x34, then reset during data bit 4 of a third frame
    dv_q.delete();
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    send_frame(8'h34, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t0);
    send_frame(8'h56, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5, t0);
    repeat (2) @(negedge CLK);
    chk_pulses("b2b", 2, 0, 0);
    check("b2b_n", 32'(dv_q.size()), 32'd2);
    check("b2b_d0", (dv_q.size() > 0) ? 32'(dv_q[0]) : 32'hDEAD, 32'h12);
    check("b2b_d1", (dv_q.size() > 1) ? 32'(dv_q[1]) : 32'hDEAD, 32'h34);
    check("abort_pdata", 32'(P_DATA), 32'h0);
    check("abort_dv", 32'(data_valid), 32'h0);
    check("abort_state", 32'(dut.state_q), 32'(RxIdle));
    RST = 1'b1;
    idle(60);
    chk_pulses("post_rst", 0, 0, 0);
    check("post_rst_pdata", 32'(P_DATA), 32'h0);
    check("post_rst_state", 32'(dut.state_q), 32'(RxIdle));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
